// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus an iterative shift-add multiply.
// Results are registered and handed off over a valid/ready handshake.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] acc_sum;

  assign accept  = in_valid && in_ready;
  assign is_mul  = (ALUControl == OP_MUL);
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    op_res = '0;
    case (ALUControl)
      3'b000:  op_res = SrcA + SrcB;
      3'b001:  op_res = SrcA - SrcB;
      3'b010:  op_res = SrcA & SrcB;
      3'b011:  op_res = SrcA | SrcB;
      3'b101:  op_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      3'b110:  op_res = SrcB;
      default: op_res = '0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      res_q    <= '0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = is_mul ? MUL : HOLD;
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = HOLD;
          res_d   = acc_sum;
          zero_d  = (acc_sum == '0);
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) state_d = is_mul ? MUL : HOLD;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (is_mul) begin
        mcand_d  = SrcA;
        mplier_d = SrcB;
        acc_d    = '0;
        count_d  = CW'(WIDTH);
      end else begin
        res_d  = op_res;
        zero_d = (op_res == '0);
      end
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      MUL:     busy = 1'b1;
      HOLD: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign ALUResult = res_q;
  assign Zero      = zero_q;

endmodule
